// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the Tnew/Tuse encoding, default mult/div latencies and the register-hazard helper.
`timescale 1ns/1ps
package pipe_stall_ctrl_pkg;

    localparam int T_WIDTH = 2;
    typedef logic [T_WIDTH-1:0] t_val_t;
    typedef logic [4:0]         reg_addr_t;

    localparam t_val_t    TUSE_NEVER          = 2'd3;
    localparam int        DEFAULT_MULT_CYCLES = 5;
    localparam int        DEFAULT_DIV_CYCLES  = 10;
    localparam reg_addr_t ZERO_REG            = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A producer blocks D when it writes the source register and its result
    // will not be forwardable before D needs it; $0 never creates a hazard.
    function automatic logic reg_hazard(input reg_addr_t src, input t_val_t tuse,
                                        input reg_addr_t dst, input t_val_t tnew);
        return (src != ZERO_REG) && (tuse != TUSE_NEVER) && (dst == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy tracker for the multi-cycle multiply/divide unit.
// Loads the operation latency on start and counts down to zero.
`timescale 1ns/1ps
module md_busy_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    md_state_e        state;

    assign state = (cnt == '0) ? MD_IDLE : MD_BUSY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

    // A start arriving while already busy is illegal upstream and is dropped here.
    always_comb begin
        cnt_next = cnt;
        case (state)
            MD_IDLE: if (start) cnt_next = is_div ? DIV_LOAD : MULT_LOAD;
            MD_BUSY: cnt_next = cnt - CNT_W'(1);
            default: cnt_next = '0;
        endcase
    end

    always_comb begin
        busy = (state == MD_BUSY);
        done = (cnt == CNT_W'(1));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller deciding whether the D-stage instruction may advance.
// Optional feature macro: STALL_CNT_EN adds a free-running stall-cycle counter output.
`timescale 1ns/1ps
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wr_addr,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_wr_addr,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        stall,
    output logic        PC_WE,
    output logic        D_WE,
    output logic        E_clr,
    output logic        md_busy,
    output logic        md_done
`ifdef STALL_CNT_EN
   ,output logic [31:0] stall_cnt
`endif
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .is_div(E_md_is_div),
        .busy  (md_busy),
        .done  (md_done)
    );

    // An md instruction must also wait for one entering E this cycle, not only one already running.
    always_comb begin
        stall_rs = reg_hazard(D_rs_addr, D_Tuse_rs, E_wr_addr, E_Tnew)
                || reg_hazard(D_rs_addr, D_Tuse_rs, M_wr_addr, M_Tnew);
        stall_rt = reg_hazard(D_rt_addr, D_Tuse_rt, E_wr_addr, E_Tnew)
                || reg_hazard(D_rt_addr, D_Tuse_rt, M_wr_addr, M_Tnew);
        stall_md = D_is_md && (md_busy || E_md_start);
        stall    = stall_rs || stall_rt || stall_md;
        PC_WE    = !stall;
        D_WE     = !stall;
        E_clr    = stall;
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard/mult/div/reset scenarios
// followed by random traffic, all checked against a cycle-numbered reference model.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wr_addr, M_wr_addr;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_is_md, E_md_start, E_md_is_div;
    logic        stall, PC_WE, D_WE, E_clr, md_busy, md_done;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] sc_model;
`endif

    int checks     = 0;
    int failures   = 0;
    int edge_count = 0;
    int busy_end   = 0;

    pipe_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_wr_addr  (E_wr_addr),
        .E_Tnew     (E_Tnew),
        .M_wr_addr  (M_wr_addr),
        .M_Tnew     (M_Tnew),
        .E_md_start (E_md_start),
        .E_md_is_div(E_md_is_div),
        .stall      (stall),
        .PC_WE      (PC_WE),
        .D_WE       (D_WE),
        .E_clr      (E_clr),
        .md_busy    (md_busy),
        .md_done    (md_done)
`ifdef STALL_CNT_EN
       ,.stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // The unit is busy in cycle numbers [start_edge, start_edge + N).
    function automatic logic model_busy();
        return edge_count < busy_end;
    endfunction

    function automatic logic model_done();
        return model_busy() && (edge_count == busy_end - 1);
    endfunction

    function automatic logic src_blocked(input logic [4:0] src, input int tuse);
        logic [4:0] dst  [2];
        int         tnew [2];
        dst[0] = E_wr_addr; tnew[0] = int'(E_Tnew);
        dst[1] = M_wr_addr; tnew[1] = int'(M_Tnew);
        if (src == 5'd0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (dst[i] == src && tnew[i] > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return src_blocked(D_rs_addr, int'(D_Tuse_rs)) || src_blocked(D_rt_addr, int'(D_Tuse_rt))
            || (D_is_md && (model_busy() || E_md_start));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic s;
        s = model_stall();
        check("stall",   32'(stall),   32'(s));
        check("PC_WE",   32'(PC_WE),   32'(!s));
        check("D_WE",    32'(D_WE),    32'(!s));
        check("E_clr",   32'(E_clr),   32'(s));
        check("md_busy", 32'(md_busy), 32'(model_busy()));
        check("md_done", 32'(md_done), 32'(model_done()));
`ifdef STALL_CNT_EN
        check("stall_cnt", stall_cnt, sc_model);
`endif
    endtask

    task automatic set_idle();
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_is_md = 1'b0; E_wr_addr = 5'd0; E_Tnew = 2'd0; M_wr_addr = 5'd0; M_Tnew = 2'd0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    // Check mid-cycle, then advance the model across the rising edge.
    task automatic apply_stimulus();
        logic was_busy;
        logic s;
        #1 check_output();
        s        = model_stall();
        was_busy = model_busy();
        @(posedge clk);
        edge_count++;
        if (!reset) begin
`ifdef STALL_CNT_EN
            if (s) sc_model = sc_model + 32'd1;
`endif
            if (E_md_start && !was_busy)
                busy_end = edge_count + (E_md_is_div ? DIV_N : MULT_N);
        end
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset    = 1'b1;
        busy_end = 0;
`ifdef STALL_CNT_EN
        sc_model = 32'd0;
`endif
    endtask

    initial begin
        set_idle();
        assert_reset();
        @(negedge clk);
        $display("[TB] reset state");
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();

        $display("[TB] load-use hazards");
        E_wr_addr = 5'd8; E_Tnew = 2'd2; D_rs_addr = 5'd8; D_Tuse_rs = 2'd1;
        apply_stimulus();
        D_Tuse_rs = 2'd2;
        apply_stimulus();
        set_idle();
        M_wr_addr = 5'd9; M_Tnew = 2'd1; D_rt_addr = 5'd9; D_Tuse_rt = 2'd0;
        apply_stimulus();
        set_idle();
        D_rt_addr = 5'd0; E_wr_addr = 5'd0; E_Tnew = 2'd2; D_Tuse_rt = 2'd0;
        apply_stimulus();
        set_idle();

        $display("[TB] mult followed by mflo");
        E_md_start = 1'b1; E_md_is_div = 1'b0;
        apply_stimulus();
        E_md_start = 1'b0; D_is_md = 1'b1;
        for (int i = 0; i < MULT_N + 1; i++) apply_stimulus();
        set_idle();

        $display("[TB] div with mfhi right behind");
        E_md_start = 1'b1; E_md_is_div = 1'b1; D_is_md = 1'b1;
        apply_stimulus();
        E_md_start = 1'b0;
        for (int i = 0; i < DIV_N + 1; i++) apply_stimulus();
        set_idle();

        $display("[TB] reset during div");
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        apply_stimulus();
        E_md_start = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus();
        #1 check("busy_before_reset", 32'(md_busy), 32'd1);
        assert_reset();
        #1 check("busy_async_reset", 32'(md_busy), 32'd0);
        apply_stimulus();
        reset = 1'b0;
        E_md_start = 1'b1; E_md_is_div = 1'b0;
        apply_stimulus();
        E_md_start = 1'b0;
        for (int i = 0; i < MULT_N + 1; i++) apply_stimulus();

`ifdef STALL_CNT_EN
        $display("[TB] stall counter over 7 stall cycles");
        set_idle();
        assert_reset();
        apply_stimulus();
        reset = 1'b0;
        E_wr_addr = 5'd4; E_Tnew = 2'd2; D_rs_addr = 5'd4; D_Tuse_rs = 2'd0;
        for (int i = 0; i < 7; i++) apply_stimulus();
        set_idle();
        #1 check("stall_cnt_7", stall_cnt, 32'd7);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            D_rs_addr   = 5'($urandom_range(0, 3));
            D_rt_addr   = 5'($urandom_range(0, 3));
            D_Tuse_rs   = 2'($urandom_range(0, 3));
            D_Tuse_rt   = 2'($urandom_range(0, 3));
            E_wr_addr   = 5'($urandom_range(0, 3));
            M_wr_addr   = 5'($urandom_range(0, 3));
            E_Tnew      = 2'($urandom_range(0, 3));
            M_Tnew      = 2'($urandom_range(0, 3));
            D_is_md     = 1'($urandom_range(0, 1));
            E_md_is_div = 1'($urandom_range(0, 1));
            E_md_start  = !model_busy() && ($urandom_range(0, 3) == 0);
            apply_stimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
